uop_sequencer: RTL

- Arbitrated micro-op injector sitting between fetch and decode of the 5-stage pipeline.
- Accepts multi-cycle control requests: CALL, RET, RTI and external interrupt.
- Replaces the fetched instruction stream with a fixed per-request sequence of 16-bit micro-ops (stack push/pop, vector load, NOP bubbles) and stalls fetch/PC until the sequence completes.
- Exactly one sequence runs at a time. Interrupts arriving mid-sequence are latched and chained.

---
 rtl/uop_pkg.sv | 26 ++
 rtl/uop_rom.sv | 46 ++++
 rtl/uop_sequencer.sv | 149 ++++++++++++++
 3 files changed

// File: rtl/uop_pkg.sv
// Shared types and micro-op encodings for the fetch/decode micro-op injector.
package uop_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_EMIT,
    ST_BUBBLE
  } state_t;

  typedef enum logic [1:0] {
    SEQ_CALL,
    SEQ_RET,
    SEQ_RTI,
    SEQ_INT
  } seq_t;

  localparam logic [15:0] PUSH_PC_LOW_OP  = 16'h5088;
  localparam logic [15:0] PUSH_PC_HIGH_OP = 16'h5089;
  localparam logic [15:0] POP_PC_HIGH_OP  = 16'h6089;
  localparam logic [15:0] POP_PC_LOW_OP   = 16'h6088;
  localparam logic [15:0] PUSH_FLAGS_OP   = 16'h5090;
  localparam logic [15:0] POP_FLAGS_OP    = 16'h6090;
  localparam logic [15:0] LOAD_VEC_OP     = 16'h7000;
  localparam logic [15:0] NOP_OP          = 16'h0000;

endpackage

// File: rtl/uop_rom.sv
// Fixed micro-op table: (sequence, step) -> micro-op plus a flag marking the
// last fixed step before any NOP bubbles.
module uop_rom
  import uop_pkg::*;
(
  input  seq_t        seq_id,
  input  logic [1:0]  step,
  output logic [15:0] uop,
  output logic        last
);

  always_comb begin
    uop  = NOP_OP;
    last = 1'b1;
    case (seq_id)
      SEQ_CALL: begin
        case (step)
          2'd0:    begin uop = PUSH_PC_LOW_OP;  last = 1'b0; end
          default: begin uop = PUSH_PC_HIGH_OP; last = 1'b1; end
        endcase
      end
      SEQ_RET: begin
        case (step)
          2'd0:    begin uop = POP_PC_HIGH_OP; last = 1'b0; end
          default: begin uop = POP_PC_LOW_OP;  last = 1'b1; end
        endcase
      end
      SEQ_RTI: begin
        case (step)
          2'd0:    begin uop = POP_FLAGS_OP;   last = 1'b0; end
          2'd1:    begin uop = POP_PC_HIGH_OP; last = 1'b0; end
          default: begin uop = POP_PC_LOW_OP;  last = 1'b1; end
        endcase
      end
      default: begin
        case (step)
          2'd0:    begin uop = PUSH_PC_LOW_OP;  last = 1'b0; end
          2'd1:    begin uop = PUSH_PC_HIGH_OP; last = 1'b0; end
          2'd2:    begin uop = PUSH_FLAGS_OP;   last = 1'b0; end
          default: begin uop = LOAD_VEC_OP;     last = 1'b1; end
        endcase
      end
    endcase
  end

endmodule

// File: rtl/uop_sequencer.sv
// Micro-op injector between fetch and decode: arbitrates CALL/RET/RTI/INT and
// replaces the instruction stream with a fixed micro-op sequence.
// Optional interrupt masking input enabled by define UOP_SEQ_INT_MASK_EN.
module uop_sequencer
  import uop_pkg::*;
#(
  parameter int unsigned RET_NOPS = 4,
  parameter int unsigned INT_NOPS = 2
) (
  input  logic        clk,
  input  logic        reset,
`ifdef UOP_SEQ_INT_MASK_EN
  input  logic        int_mask,
`endif
  input  logic        int_req,
  input  logic        rti_req,
  input  logic        ret_req,
  input  logic        call_req,
  output logic        ack,
  output logic [15:0] uop,
  output logic        uop_valid,
  output logic        stall,
  output logic        busy,
  output logic        done
);

  localparam logic [3:0] RET_N = 4'(RET_NOPS);
  localparam logic [3:0] INT_N = 4'(INT_NOPS);

  state_t      state, state_nx;
  seq_t        seq_id, seq_nx;
  logic [1:0]  step, step_nx;
  logic [3:0]  nop_cnt, nop_nx;
  logic        int_pending, pend_nx;
  logic        ack_q, ack_nx;
  logic        finish;
  logic [15:0] rom_uop;
  logic        rom_last;
  logic [3:0]  seq_nops;
  logic        int_in, int_go, int_masked;

`ifdef UOP_SEQ_INT_MASK_EN
  assign int_masked = int_mask;
`else
  assign int_masked = 1'b0;
`endif

  uop_rom u_rom (
    .seq_id (seq_id),
    .step   (step),
    .uop    (rom_uop),
    .last   (rom_last)
  );

  assign seq_nops = (seq_id == SEQ_INT)  ? INT_N :
                    (seq_id == SEQ_CALL) ? 4'd0  : RET_N;

  // A same-cycle int_req counts as pending for both arbitration and chaining.
  assign int_in = int_pending | int_req;
  assign int_go = int_in & ~int_masked;

  // Decode requests are levels held until ack; ack pulses the cycle after the
  // edge that accepted the request, alongside the first micro-op.
  always_comb begin
    state_nx = state;
    seq_nx   = seq_id;
    step_nx  = step;
    nop_nx   = nop_cnt;
    pend_nx  = int_in;
    ack_nx   = 1'b0;
    finish   = 1'b0;
    case (state)
      ST_IDLE: begin
        step_nx = 2'd0;
        nop_nx  = 4'd0;
        if (int_go) begin
          state_nx = ST_EMIT;
          seq_nx   = SEQ_INT;
          pend_nx  = 1'b0;
        end else if (rti_req) begin
          state_nx = ST_EMIT;
          seq_nx   = SEQ_RTI;
          ack_nx   = 1'b1;
        end else if (ret_req) begin
          state_nx = ST_EMIT;
          seq_nx   = SEQ_RET;
          ack_nx   = 1'b1;
        end else if (call_req) begin
          state_nx = ST_EMIT;
          seq_nx   = SEQ_CALL;
          ack_nx   = 1'b1;
        end
      end
      ST_EMIT: begin
        if (!rom_last) begin
          step_nx = step + 2'd1;
        end else if (seq_nops != 4'd0) begin
          state_nx = ST_BUBBLE;
          nop_nx   = seq_nops;
        end else begin
          finish = 1'b1;
        end
      end
      ST_BUBBLE: begin
        if (nop_cnt == 4'd1) finish = 1'b1;
        else                 nop_nx = nop_cnt - 4'd1;
      end
      default: state_nx = ST_IDLE;
    endcase
    if (finish) begin
      step_nx = 2'd0;
      nop_nx  = 4'd0;
      if (int_go) begin
        state_nx = ST_EMIT;
        seq_nx   = SEQ_INT;
        pend_nx  = 1'b0;
      end else begin
        state_nx = ST_IDLE;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state       <= ST_IDLE;
      seq_id      <= SEQ_CALL;
      step        <= 2'd0;
      nop_cnt     <= 4'd0;
      int_pending <= 1'b0;
      ack_q       <= 1'b0;
    end else begin
      state       <= state_nx;
      seq_id      <= seq_nx;
      step        <= step_nx;
      nop_cnt     <= nop_nx;
      int_pending <= pend_nx;
      ack_q       <= ack_nx;
    end
  end

  assign uop       = (state == ST_EMIT) ? rom_uop : NOP_OP;
  assign uop_valid = (state != ST_IDLE);
  assign stall     = (state != ST_IDLE);
  assign busy      = (state != ST_IDLE) | int_pending;
  assign ack       = ack_q;
  assign done      = ((state == ST_EMIT) & rom_last & (seq_nops == 4'd0)) |
                     ((state == ST_BUBBLE) & (nop_cnt == 4'd1));

endmodule
